i3c_bus_sequencer: RTL and testbench

//  Transaction sequencer and requester arbiter in front of the I3C bus controller.

---
 rtl/i3c_bus_sequencer_pkg.sv | 14 +
 rtl/i3c_rr_arbiter.sv | 25 ++
 rtl/i3c_bus_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_i3c_bus_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/i3c_bus_sequencer_pkg.sv
// Shared phase encoding and widths for the I3C bus sequencer slice.
package i3c_bus_sequencer_pkg;
    localparam int BYTE_W     = 8;
    localparam int ADDR_W_STD = 7;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_START = 3'd1,
        PH_ADDR  = 3'd2,
        PH_ACK   = 3'd3,
        PH_DATA  = 3'd4,
        PH_STOP  = 3'd5
    } phase_e;
endpackage

// File: rtl/i3c_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module i3c_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // Outer loop walks the distance from ptr, so the nearest requester wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req[k] && (k == (int'(ptr) + i) % NUM_REQ)) begin
                    gnt[k] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/i3c_bus_sequencer.sv
// Arbitrates single-byte commands and steps the bus controller through
// START/ADDR/ACK/DATA/ACK/STOP, one phase step per SCL bit tick.
module i3c_bus_sequencer
    import i3c_bus_sequencer_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_STD
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0]         req_rnw_i,
    input  logic [NUM_REQ*BYTE_W-1:0]  req_wdata_i,
    input  logic                       bit_tick_i,
    input  logic                       sda_i,
    input  logic                       abort_i,
    output logic [2:0]                 state_o,
    output logic                       sda_bit_o,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       nack_o,
    output logic [BYTE_W-1:0]          rdata_o
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    phase_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [BYTE_W-1:0]   sh_q, sh_d;
    logic [BYTE_W-1:0]   wdata_q, wdata_d;
    logic [BYTE_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                rnw_q, rnw_d;
    logic                ack_data_q, ack_data_d;
    logic                nack_q, nack_d;
    logic                abort_q, abort_d;
    logic                done_q, done_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [BYTE_W-1:0]   sel_wdata;
    logic                sel_rnw;
    logic [PTR_W-1:0]    nxt_ptr;
    logic                accept;
    logic                abort_hit;

    i3c_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req (req_valid_i),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    // The cycle carrying done_o is kept free so completion and a new grant never coincide.
    assign accept      = (state_q == PH_IDLE) && !done_q && (|req_valid_i);
    assign req_ready_o = accept ? arb_gnt : '0;
    assign abort_hit   = abort_q | abort_i;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rnw   = 1'b0;
        nxt_ptr   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
                sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[k*BYTE_W +: BYTE_W];
                sel_rnw   = req_rnw_i[k];
                nxt_ptr   = PTR_W'((k + 1) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        rnw_d      = rnw_q;
        ack_data_d = ack_data_q;
        nack_d     = nack_q;
        abort_d    = abort_q;
        done_d     = 1'b0;

        if (state_q inside {PH_START, PH_ADDR, PH_ACK, PH_DATA} && abort_i)
            abort_d = 1'b1;

        case (state_q)
            PH_IDLE: begin
                if (accept) begin
                    state_d = PH_START;
                    grant_d = arb_gnt;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    rnw_d   = sel_rnw;
                    ptr_d   = nxt_ptr;
                    nack_d  = 1'b0;
                    abort_d = 1'b0;
                end
            end
            PH_START: begin
                if (bit_tick_i) begin
                    if (abort_hit) begin
                        state_d = PH_STOP;
                        nack_d  = 1'b1;
                    end else begin
                        state_d = PH_ADDR;
                        cnt_d   = 3'd7;
                        sh_d    = BYTE_W'({addr_q, rnw_q});
                    end
                end
            end
            PH_ADDR: begin
                if (bit_tick_i) begin
                    if (abort_hit) begin
                        state_d = PH_STOP;
                        nack_d  = 1'b1;
                    end else begin
                        sh_d = {sh_q[BYTE_W-2:0], 1'b0};
                        if (cnt_q == 3'd0) begin
                            state_d    = PH_ACK;
                            ack_data_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
            end
            PH_ACK: begin
                if (bit_tick_i) begin
                    if (abort_hit) begin
                        state_d = PH_STOP;
                        nack_d  = 1'b1;
                    end else if (!ack_data_q) begin
                        if (sda_i) begin
                            state_d = PH_STOP;
                            nack_d  = 1'b1;
                        end else begin
                            state_d = PH_DATA;
                            cnt_d   = 3'd7;
                            sh_d    = rnw_q ? '0 : wdata_q;
                        end
                    end else begin
                        // A read ends with our own NACK, so only write data can be refused.
                        if (!rnw_q && sda_i)
                            nack_d = 1'b1;
                        state_d = PH_STOP;
                    end
                end
            end
            PH_DATA: begin
                if (bit_tick_i) begin
                    if (abort_hit) begin
                        state_d = PH_STOP;
                        nack_d  = 1'b1;
                    end else begin
                        sh_d = {sh_q[BYTE_W-2:0], rnw_q ? sda_i : 1'b0};
                        if (cnt_q == 3'd0) begin
                            state_d    = PH_ACK;
                            ack_data_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
            end
            PH_STOP: begin
                if (bit_tick_i) begin
                    state_d = PH_IDLE;
                    done_d  = 1'b1;
                    grant_d = '0;
                    abort_d = 1'b0;
                    if (rnw_q && !nack_q)
                        rdata_d = sh_q;
                end
            end
            default: state_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PH_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            grant_q    <= '0;
            ptr_q      <= '0;
            rnw_q      <= 1'b0;
            ack_data_q <= 1'b0;
            nack_q     <= 1'b0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            rnw_q      <= rnw_d;
            ack_data_q <= ack_data_d;
            nack_q     <= nack_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        sda_bit_o = 1'b1;
        if (state_q == PH_ADDR || (state_q == PH_DATA && !rnw_q))
            sda_bit_o = sh_q[BYTE_W-1];
    end

    assign state_o = state_q;
    assign grant_o = grant_q;
    assign busy_o  = (state_q != PH_IDLE);
    assign done_o  = done_q;
    assign nack_o  = done_q & nack_q;
    assign rdata_o = rdata_q;
endmodule

// File: tb/tb_i3c_bus_sequencer.sv
// Directed bench for i3c_bus_sequencer with two requesters.
module tb_i3c_bus_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [13:0] req_addr_i;
    logic [1:0]  req_rnw_i;
    logic [15:0] req_wdata_i;
    logic        bit_tick_i;
    logic        sda_i;
    logic        abort_i;
    logic [2:0]  state_o;
    logic        sda_bit_o;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic        done_o;
    logic        nack_o;
    logic [7:0]  rdata_o;

    int errors = 0;
    int checks = 0;

    i3c_bus_sequencer #(.NUM_REQ(2), .ADDR_W(7)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_rnw_i   (req_rnw_i),
        .req_wdata_i (req_wdata_i),
        .bit_tick_i  (bit_tick_i),
        .sda_i       (sda_i),
        .abort_i     (abort_i),
        .state_o     (state_o),
        .sda_bit_o   (sda_bit_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .nack_o      (nack_o),
        .rdata_o     (rdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; holds the tick across exactly one rising edge.
    task automatic do_tick(input logic s);
        sda_i      = s;
        bit_tick_i = 1'b1;
        @(negedge clk_i);
        bit_tick_i = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        for (int c = 0; c < 8 && !busy_o; c++) @(negedge clk_i);
        chk(tag, 32'(busy_o), 32'h1);
    endtask

    logic [7:0] cap;
    logic       all_ones;
    logic [7:0] rd_byte;
    logic [1:0] exp_g [4];

    initial begin
        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
        rst_i = 1'b1; req_valid_i = '0; req_addr_i = '0; req_rnw_i = '0;
        req_wdata_i = '0; bit_tick_i = 1'b0; sda_i = 1'b1; abort_i = 1'b0;
        #3;
        chk("rst_state", 32'(state_o), 32'h0);
        chk("rst_sda_bit", 32'(sda_bit_o), 32'h1);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_rdata", 32'(rdata_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // T1: write 0xA5 to 0x50 from requester 0
        req_addr_i = {7'h00, 7'h50}; req_wdata_i = {8'h00, 8'hA5}; req_rnw_i = 2'b00;
        req_valid_i = 2'b01;
        #1 chk("t1_ready", 32'(req_ready_o), 32'h1);
        @(negedge clk_i);
        chk("t1_start", 32'(state_o), 32'h1);
        chk("t1_grant", 32'(grant_o), 32'h1);
        chk("t1_ready_pulse", 32'(req_ready_o), 32'h0);
        req_valid_i = 2'b00;
        do_tick(1'b0);
        cap = '0;
        for (int i = 0; i < 8; i++) begin cap = {cap[6:0], sda_bit_o}; do_tick(1'b0); end
        chk("t1_addr_bits", 32'(cap), 32'hA0);
        chk("t1_ack_state", 32'(state_o), 32'h3);
        chk("t1_ack_release", 32'(sda_bit_o), 32'h1);
        do_tick(1'b0);
        chk("t1_data_state", 32'(state_o), 32'h4);
        cap = '0;
        for (int i = 0; i < 8; i++) begin cap = {cap[6:0], sda_bit_o}; do_tick(1'b0); end
        chk("t1_data_bits", 32'(cap), 32'hA5);
        do_tick(1'b0);
        chk("t1_stop", 32'(state_o), 32'h5);
        do_tick(1'b0);
        chk("t1_done", 32'(done_o), 32'h1);
        chk("t1_nack", 32'(nack_o), 32'h0);
        chk("t1_idle", 32'(state_o), 32'h0);
        chk("t1_grant_clr", 32'(grant_o), 32'h0);

        // T2: read from 0x3C by requester 1, offered in the done cycle
        req_addr_i = {7'h3C, 7'h00}; req_rnw_i = 2'b10; req_valid_i = 2'b10;
        #1 chk("t2_blocked_in_done", 32'(req_ready_o), 32'h0);
        @(negedge clk_i);
        #1 chk("t2_ready", 32'(req_ready_o), 32'h2);
        @(negedge clk_i);
        chk("t2_grant", 32'(grant_o), 32'h2);
        req_valid_i = 2'b00;
        do_tick(1'b0);
        cap = '0;
        for (int i = 0; i < 8; i++) begin cap = {cap[6:0], sda_bit_o}; do_tick(1'b0); end
        chk("t2_addr_bits", 32'(cap), 32'h79);
        do_tick(1'b0);
        rd_byte = 8'h96;
        all_ones = 1'b1;
        for (int i = 7; i >= 0; i--) begin all_ones &= sda_bit_o; do_tick(rd_byte[i]); end
        chk("t2_read_release", 32'(all_ones), 32'h1);
        do_tick(1'b1);
        do_tick(1'b0);
        chk("t2_done", 32'(done_o), 32'h1);
        chk("t2_nack", 32'(nack_o), 32'h0);
        chk("t2_rdata", 32'(rdata_o), 32'h96);

        // T3: address NACK ends the transfer at tick 11
        @(negedge clk_i);
        req_addr_i = {7'h00, 7'h50}; req_rnw_i = 2'b00; req_valid_i = 2'b01;
        @(negedge clk_i);
        chk("t3_grant", 32'(grant_o), 32'h1);
        req_valid_i = 2'b00;
        for (int i = 0; i < 9; i++) do_tick(1'b0);
        do_tick(1'b1);
        chk("t3_stop", 32'(state_o), 32'h5);
        do_tick(1'b0);
        chk("t3_done", 32'(done_o), 32'h1);
        chk("t3_nack", 32'(nack_o), 32'h1);
        chk("t3_rdata_kept", 32'(rdata_o), 32'h96);

        // T4: both requesters valid continuously
        req_valid_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_busy("t4_accept");
            chk("t4_grant", 32'(grant_o), 32'(exp_g[t]));
            for (int i = 0; i < 11; i++) do_tick(1'b1);
            chk("t4_done", 32'(done_o), 32'h1);
            chk("t4_nack", 32'(nack_o), 32'h1);
        end
        req_valid_i = 2'b00;

        // T5: abort while DATA bit 3 is on the bus
        @(negedge clk_i);
        req_addr_i = {7'h3C, 7'h00}; req_wdata_i = {8'hFF, 8'h00}; req_rnw_i = 2'b00;
        req_valid_i = 2'b10;
        wait_busy("t5_accept");
        chk("t5_grant", 32'(grant_o), 32'h2);
        req_valid_i = 2'b00;
        for (int i = 0; i < 14; i++) do_tick(1'b0);
        chk("t5_in_data", 32'(state_o), 32'h4);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("t5_wait_tick", 32'(state_o), 32'h4);
        do_tick(1'b0);
        chk("t5_stop", 32'(state_o), 32'h5);
        do_tick(1'b0);
        chk("t5_done", 32'(done_o), 32'h1);
        chk("t5_nack", 32'(nack_o), 32'h1);
        chk("t5_grant_clr", 32'(grant_o), 32'h0);

        // T7: tick coinciding with the grant is not consumed by START
        @(negedge clk_i);
        req_addr_i = {7'h00, 7'h50}; req_valid_i = 2'b01; bit_tick_i = 1'b1;
        @(negedge clk_i);
        bit_tick_i = 1'b0; req_valid_i = 2'b00;
        chk("t7_start", 32'(state_o), 32'h1);
        chk("t7_grant", 32'(grant_o), 32'h1);
        do_tick(1'b0);
        chk("t7_addr", 32'(state_o), 32'h2);
        do_tick(1'b0);
        do_tick(1'b0);

        // T6: asynchronous reset in the middle of ADDR
        #2 rst_i = 1'b1;
        #1;
        chk("t6_state", 32'(state_o), 32'h0);
        chk("t6_grant", 32'(grant_o), 32'h0);
        chk("t6_busy", 32'(busy_o), 32'h0);
        chk("t6_sda_bit", 32'(sda_bit_o), 32'h1);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
